// File: rtl/coms_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : coms_frame_rx
// Purpose  : Hunts a 32-bit sync word in a UART byte stream, collects a fixed
//            frame, checks its CRC16 (0x8005) and publishes the payload.
// Revision : 1.0 - initial release
// ============================================================================
module coms_frame_rx #(
  parameter int          FRAME_LENGTH = 20,
  parameter logic [31:0] MAGICNUMBER  = 32'hDABBAD00,
  parameter int          TIMEOUT      = 50000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          rx_data_ready,
  input  logic [7:0]                    rx_data,
  output logic [8*(FRAME_LENGTH-6)-1:0] payload,
  output logic                          frame_valid,
  output logic                          crc_error,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic [15:0]                   error_count
);

  localparam int PLEN = FRAME_LENGTH - 6;
  localparam int IW   = $clog2(FRAME_LENGTH);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_IDX   = IW'(FRAME_LENGTH - 1);
  localparam logic [IW-1:0] CRC_START  = IW'(FRAME_LENGTH - 3);
  localparam logic [IW-1:0] FIRST_DATA = IW'(4);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    COMPARE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         window_q, window_d;
  logic [7:0]          frame_q [FRAME_LENGTH];
  logic [7:0]          frame_d [FRAME_LENGTH];
  logic [IW-1:0]       idx_q, idx_d;
  logic [15:0]         crc_q, crc_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic [8*PLEN-1:0]   payload_q, payload_d;
  logic                fv_q, fv_d;
  logic                ce_q, ce_d;
  logic [15:0]         fc_q, fc_d;
  logic [15:0]         ec_q, ec_d;

  // One byte through the non-reflected 0x8005 shift register, MSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    window_d  = rx_data_ready ? {window_q[23:0], rx_data} : window_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    idle_d    = '0;
    payload_d = payload_q;
    fv_d      = 1'b0;
    ce_d      = 1'b0;
    fc_d      = fc_q;
    ec_d      = ec_q;

    case (state_q)
      HUNT: begin
        idx_d = '0;
        if (rx_data_ready && (window_d == MAGICNUMBER)) begin
          frame_d[0] = window_d[31:24];
          frame_d[1] = window_d[23:16];
          frame_d[2] = window_d[15:8];
          frame_d[3] = window_d[7:0];
          idx_d      = FIRST_DATA;
          state_d    = COLLECT;
        end
      end

      COLLECT: begin
        if (rx_data_ready) begin
          frame_d[idx_q] = rx_data;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = CRC_START;
            crc_d   = 16'hFFFF;
            state_d = CHECK;
          end
        end else if (idle_q == IDLE_LIMIT) begin
          if (ec_q != 16'hFFFF) ec_d = ec_q + 16'd1;
          idx_d   = '0;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      CHECK: begin
        crc_d = crc_byte(crc_q, frame_q[idx_q]);
        if (idx_q == '0) state_d = COMPARE;
        else             idx_d   = idx_q - 1'b1;
      end

      COMPARE: begin
        // The two trailing bytes carry the CRC high byte first.
        if (crc_q == {frame_q[LAST_IDX-1'b1], frame_q[LAST_IDX]}) begin
          for (int k = 0; k < PLEN; k++) payload_d[8*k +: 8] = frame_q[4+k];
          fv_d = 1'b1;
          if (fc_q != 16'hFFFF) fc_d = fc_q + 16'd1;
        end else begin
          ce_d = 1'b1;
          if (ec_q != 16'hFFFF) ec_d = ec_q + 16'd1;
        end
        idx_d   = '0;
        state_d = HUNT;
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= HUNT;
      window_q  <= '0;
      for (int i = 0; i < FRAME_LENGTH; i++) frame_q[i] <= '0;
      idx_q     <= '0;
      crc_q     <= 16'hFFFF;
      idle_q    <= '0;
      payload_q <= '0;
      fv_q      <= 1'b0;
      ce_q      <= 1'b0;
      fc_q      <= '0;
      ec_q      <= '0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      idle_q    <= idle_d;
      payload_q <= payload_d;
      fv_q      <= fv_d;
      ce_q      <= ce_d;
      fc_q      <= fc_d;
      ec_q      <= ec_d;
    end
  end

  // COMPARE counts as busy so that busy drops together with the result pulse.
  assign busy        = (state_q != HUNT);
  assign payload     = payload_q;
  assign frame_valid = fv_q;
  assign crc_error   = ce_q;
  assign frame_count = fc_q;
  assign error_count = ec_q;

endmodule
`default_nettype wire

// File: tb/tb_coms_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_coms_frame_rx
// Purpose  : Directed self-checking bench for coms_frame_rx.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_coms_frame_rx;

  localparam int TIMEOUT = 50000;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         rx_data_ready = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic [111:0] payload;
  logic         frame_valid, crc_error, busy;
  logic [15:0]  frame_count, error_count;

  int vectors     = 0;
  int miscompares = 0;
  int fv_seen     = 0;
  int fv_base     = 0;

  logic [7:0]   fr [20];
  logic [111:0] pl_hold;
  logic [7:0]   good_pl [14] = '{8'hD0, 8'hD0, 8'hCA, 8'hCA, 8'hD0, 8'hD0, 8'h12,
                                  8'h34, 8'hCA, 8'hCA, 8'hD0, 8'hD0, 8'hCA, 8'hCA};
  logic [7:0]   alt_pl  [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};

  coms_frame_rx #(.FRAME_LENGTH(20), .MAGICNUMBER(32'hDABBAD00), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .payload(payload), .frame_valid(frame_valid), .crc_error(crc_error),
    .busy(busy), .frame_count(frame_count), .error_count(error_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (frame_valid === 1'b1) fv_seen++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden frame: magic, payload, then CRC of the 144-bit word {b17..b0} MSB first.
  task automatic load_frame(input logic [7:0] pl [14]);
    logic [143:0] w;
    logic [15:0]  c;
    logic         fb;
    fr[0] = 8'hDA; fr[1] = 8'hBB; fr[2] = 8'hAD; fr[3] = 8'h00;
    for (int k = 0; k < 14; k++) fr[4+k] = pl[k];
    for (int k = 0; k < 18; k++) w[8*k +: 8] = fr[k];
    c = 16'hFFFF;
    for (int i = 143; i >= 0; i--) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    fr[18] = c[15:8];
    fr[19] = c[7:0];
  endtask

  function automatic logic [111:0] exp_pl();
    logic [111:0] p;
    for (int k = 0; k < 14; k++) p[8*k +: 8] = fr[4+k];
    return p;
  endfunction

  // Leaves the caller in the middle of the cycle after the strobe.
  task automatic send_byte_nowait(input logic [7:0] b);
    @(negedge CLK);
    rx_data_ready = 1'b1;
    rx_data       = b;
    @(negedge CLK);
    rx_data_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_nowait(b);
    repeat (19) @(negedge CLK);
  endtask

  task automatic send_frame();
    for (int i = 0; i < 19; i++) send_byte(fr[i]);
    send_byte_nowait(fr[19]);
  endtask

  // Called mid T+1 after the last byte; checks T+19, T+20 and T+21.
  task automatic check_end(input string tag, input bit ok, input logic [15:0] fc_e,
                           input logic [15:0] ec_e, input logic [111:0] pl_e);
    repeat (18) @(negedge CLK);
    chk({tag, " fv@T+19"}, frame_valid, 1'b0);
    chk({tag, " busy@T+19"}, busy, 1'b1);
    @(negedge CLK);
    chk({tag, " fv@T+20"}, frame_valid, ok);
    chk({tag, " ce@T+20"}, crc_error, !ok);
    chk({tag, " busy@T+20"}, busy, 1'b0);
    chk({tag, " frame_count"}, frame_count, fc_e);
    chk({tag, " error_count"}, error_count, ec_e);
    chk({tag, " payload"}, payload, pl_e);
    @(negedge CLK);
    chk({tag, " pulses@T+21"}, {frame_valid, crc_error}, 2'b00);
  endtask

  initial begin
    // Reset state
    @(negedge CLK);
    chk("reset outputs", {payload, frame_valid, crc_error, busy, frame_count, error_count}, '0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset mid-stream, asynchronous
    send_byte(8'hDA); send_byte(8'hBB); send_byte(8'hAD); send_byte(8'h00);
    chk("busy after magic", busy, 1'b1);
    send_byte(8'h55);
    #2 RST = 1'b1;
    #1 chk("async reset busy", busy, 1'b0);
    chk("async reset outputs", {payload, frame_valid, crc_error, frame_count, error_count}, '0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Good frame
    load_frame(good_pl);
    fv_base = fv_seen;
    send_frame();
    check_end("good", 1'b1, 16'd1, 16'd0, exp_pl());
    chk("good pl[7:0]", payload[7:0], 8'hD0);
    chk("good pl[55:48]", payload[55:48], 8'h12);
    chk("good pl[63:56]", payload[63:56], 8'h34);
    chk("good fv pulses", fv_seen - fv_base, 1);
    pl_hold = payload;

    // Bad CRC: low CRC byte flipped
    fr[19] = fr[19] ^ 8'h01;
    fv_base = fv_seen;
    send_frame();
    check_end("badcrc", 1'b0, 16'd1, 16'd1, pl_hold);
    chk("badcrc fv pulses", fv_seen - fv_base, 0);

    // Resync through a false start, different payload
    send_byte(8'hDA); send_byte(8'hBB); send_byte(8'h55); send_byte(8'hDA);
    load_frame(alt_pl);
    fv_base = fv_seen;
    send_frame();
    check_end("resync", 1'b1, 16'd2, 16'd1, exp_pl());
    chk("resync pl[7:0]", payload[7:0], 8'h01);
    chk("resync pl[111:104]", payload[111:104], 8'h0E);
    chk("resync fv pulses", fv_seen - fv_base, 1);

    // Timeout: magic plus 5 bytes then silence
    send_byte(8'hDA); send_byte(8'hBB); send_byte(8'hAD); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte_nowait(8'h55);
    repeat (TIMEOUT - 1) @(negedge CLK);
    chk("timeout busy@limit", busy, 1'b1);
    chk("timeout ec@limit", error_count, 16'd1);
    @(negedge CLK);
    chk("timeout busy after", busy, 1'b0);
    chk("timeout ec after", error_count, 16'd2);
    repeat (2) @(negedge CLK);
    load_frame(good_pl);
    fv_base = fv_seen;
    send_frame();
    check_end("post-timeout", 1'b1, 16'd3, 16'd2, exp_pl());
    chk("post-timeout fv pulses", fv_seen - fv_base, 1);

    // Reset during CHECK
    fv_base = fv_seen;
    send_frame();
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1 chk("rst-check busy", busy, 1'b0);
    chk("rst-check counters", {frame_count, error_count}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    chk("rst-check no pulse", fv_seen - fv_base, 0);
    chk("rst-check no crc_error", crc_error, 1'b0);
    send_frame();
    check_end("after-rst", 1'b1, 16'd1, 16'd0, exp_pl());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
